hazard_unit: RTL

Parametrised hazard and forwarding controller for the five-stage pipelined successor of the single-cycle core. It keeps its own shadow pipeline of register-usage information for the E, M and W stages. From that it drives operand-forwarding selects, load-use stalls, branch flushes and whole-pipe freezes on data-cache misses. It also provides saturating performance counters for stall, flush and load-use events. It sits beside the pipeline registers at top level and replaces all ad-hoc hazard logic.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/sat_counter.sv | 18 +
 rtl/hazard_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
  localparam int unsigned STAGE_REG_W = 5;

  // Register-usage record carried alongside each pipeline register.
  typedef struct packed {
    logic [STAGE_REG_W-1:0] rs1;
    logic [STAGE_REG_W-1:0] rs2;
    logic [STAGE_REG_W-1:0] rd;
    logic                   RegWrite;
    logic                   isLoad;
  } stage_info_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous active-low clear.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller: shadows E/M/W register usage and drives
// forwarding selects, load-use stalls, branch flushes and cache-miss freezes.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
  input  logic [REG_ADDR_WIDTH-1:0] rdD_i,
  input  logic                      RegWriteD_i,
  input  logic [1:0]                ResultSrcD_i,
  input  logic                      branchTakenE_i,
  input  logic                      memBusyM_i,
  output logic                      stallF_o,
  output logic                      stallD_o,
  output logic                      stallE_o,
  output logic                      stallM_o,
  output logic                      flushD_o,
  output logic                      flushE_o,
  output logic [1:0]                fwdAE_o,
  output logic [1:0]                fwdBE_o,
  output logic [CNT_WIDTH-1:0]      stallCnt_o,
  output logic [CNT_WIDTH-1:0]      flushCnt_o,
  output logic [CNT_WIDTH-1:0]      loadUseCnt_o
);

  logic [REG_ADDR_WIDTH-1:0] rs1E, rs2E, rdE, rdM, rdW;
  logic regWriteE, isLoadE, regWriteM, regWriteW;
  logic loadUse, loadUseApplied;
  fwd_sel_t fwdA, fwdB;

  function automatic fwd_sel_t fwdSel(
    input logic [REG_ADDR_WIDTH-1:0] rsE,
    input logic [REG_ADDR_WIDTH-1:0] rdMs,
    input logic                      rwM,
    input logic [REG_ADDR_WIDTH-1:0] rdWs,
    input logic                      rwW
  );
    if (rwM && (rdMs != '0) && (rdMs == rsE))
      return FWD_M;
    else if (rwW && (rdWs != '0) && (rdWs == rsE))
      return FWD_W;
    else
      return FWD_REG;
  endfunction

  assign loadUse = isLoadE && regWriteE && (rdE != '0) &&
                   ((rdE == rs1D_i) || (rdE == rs2D_i));

  // Priority: reset forces idle, then freeze, then branch flush, then load-use.
  always_comb begin
    stallF_o       = 1'b0;
    stallD_o       = 1'b0;
    stallE_o       = 1'b0;
    stallM_o       = 1'b0;
    flushD_o       = 1'b0;
    flushE_o       = 1'b0;
    loadUseApplied = 1'b0;
    fwdA           = FWD_REG;
    fwdB           = FWD_REG;
    if (rst) begin
      fwdA = fwdSel(rs1E, rdM, regWriteM, rdW, regWriteW);
      fwdB = fwdSel(rs2E, rdM, regWriteM, rdW, regWriteW);
      if (memBusyM_i) begin
        stallF_o = 1'b1;
        stallD_o = 1'b1;
        stallE_o = 1'b1;
        stallM_o = 1'b1;
      end else if (branchTakenE_i) begin
        flushD_o = 1'b1;
        flushE_o = 1'b1;
      end else if (loadUse) begin
        stallF_o       = 1'b1;
        stallD_o       = 1'b1;
        flushE_o       = 1'b1;
        loadUseApplied = 1'b1;
      end
    end
  end

  assign fwdAE_o = fwdA;
  assign fwdBE_o = fwdB;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rs1E <= '0; rs2E <= '0; rdE <= '0; regWriteE <= 1'b0; isLoadE <= 1'b0;
      rdM  <= '0; regWriteM <= 1'b0;
      rdW  <= '0; regWriteW <= 1'b0;
    end else if (!memBusyM_i) begin
      rdW       <= rdM;
      regWriteW <= regWriteM;
      rdM       <= rdE;
      regWriteM <= regWriteE;
      if (flushE_o) begin
        rs1E <= '0; rs2E <= '0; rdE <= '0; regWriteE <= 1'b0; isLoadE <= 1'b0;
      end else begin
        rs1E      <= rs1D_i;
        rs2E      <= rs2D_i;
        rdE       <= rdD_i;
        regWriteE <= RegWriteD_i;
        isLoadE   <= (ResultSrcD_i == RESULT_SRC_LOAD);
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) uStallCnt (
    .clk(clk), .rst(rst), .inc(stallF_o), .count(stallCnt_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) uFlushCnt (
    .clk(clk), .rst(rst), .inc(flushD_o), .count(flushCnt_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) uLoadUseCnt (
    .clk(clk), .rst(rst), .inc(loadUseApplied), .count(loadUseCnt_o)
  );

endmodule
